// File: rtl/melody_score_seq_n.sv
// Score sequencer: steps an N-slot score from a sync ROM at a fixed tempo and writes
// note/divisor to each tone slot every beat. Optional transpose: MELODY_SEQ_TRANSPOSE_EN.
module melody_score_seq_n #(
  parameter int unsigned C_SLOT_N   = 2,
  parameter int unsigned C_SCORE_W  = 4,
  parameter int unsigned C_TEMPO_TC = 357,
  localparam int unsigned SW = (C_SLOT_N > 1) ? $clog2(C_SLOT_N) : 1
) (
  input  logic                    CK_i,
  input  logic                    XAR_i,
  input  logic                    TIMING_1ms_i,
  input  logic                    START_i,
  input  logic                    STOP_i,
  input  logic                    LOOP_i,
`ifdef MELODY_SEQ_TRANSPOSE_EN
  input  logic [4:0]              TRANSPOSE_i,
`endif
  output logic [SW+C_SCORE_W-1:0] SCORE_ADRs_o,
  input  logic [5:0]              SCORE_DATs_i,
  output logic                    tempo_o,
  output logic [7:0]              SLOT_divs_o,
  output logic                    SLOT_note_o,
  output logic [C_SLOT_N-1:0]     SLOTs_WT_REQ_o,
  output logic [C_SCORE_W-1:0]    STEP_o,
  output logic                    BUSY_o,
  output logic                    DONE_o
);

  localparam int unsigned TW = $clog2(C_TEMPO_TC);
  localparam logic [TW-1:0] TempoReload = TW'(C_TEMPO_TC - 1);
  localparam logic [SW-1:0] LastSlot = SW'(C_SLOT_N - 1);
  localparam logic [C_SCORE_W-1:0] LastStep = '1;

  // Equal-tempered divisors minus one, O4G+ (code 0) up to O7D+ (code 31).
  localparam logic [7:0] DivLut [32] = '{
    8'd240, 8'd226, 8'd214, 8'd202, 8'd190, 8'd180, 8'd169, 8'd160,
    8'd151, 8'd142, 8'd134, 8'd127, 8'd120, 8'd113, 8'd106, 8'd100,
    8'd95,  8'd89,  8'd84,  8'd79,  8'd75,  8'd71,  8'd67,  8'd63,
    8'd59,  8'd56,  8'd53,  8'd50,  8'd47,  8'd44,  8'd42,  8'd39
  };

  typedef enum logic [1:0] {StIdle, StArmed, StPlay} state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         ctr_q, ctr_d;
  logic                  arm_q, arm_d;
  logic [C_SCORE_W-1:0]  step_q, step_d;
  logic                  done_q, done_d;
  logic                  sw_q, sw_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic                  v1_q, v1_d;
  logic [SW-1:0]         slot1_q;
  logic [C_SLOT_N-1:0]   wt_q, wt_d;
  logic [7:0]            divs_q, divs_d;
  logic                  note_q, note_d;
  logic                  tick, launch;
  logic [4:0]            code_eff;

  assign tick = TIMING_1ms_i & (ctr_q == '0);

`ifdef MELODY_SEQ_TRANSPOSE_EN
  logic signed [6:0] code_sum;
  always_comb begin
    code_sum = $signed({2'b00, SCORE_DATs_i[4:0]}) + $signed({{2{TRANSPOSE_i[4]}}, TRANSPOSE_i});
    if (code_sum < 0)            code_eff = 5'd0;
    else if (code_sum > 7'sd31)  code_eff = 5'd31;
    else                         code_eff = code_sum[4:0];
  end
`else
  assign code_eff = SCORE_DATs_i[4:0];
`endif

  always_comb begin
    ctr_d = ctr_q;
    if (TIMING_1ms_i) ctr_d = (ctr_q == '0) ? TempoReload : ctr_q - 1'b1;

    arm_d = arm_q;
    if (tick)    arm_d = 1'b0;
    if (START_i) arm_d = 1'b1;
    if (STOP_i)  arm_d = 1'b0;

    state_d = state_q;
    step_d  = step_q;
    done_d  = 1'b0;
    launch  = 1'b0;
    if (STOP_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (START_i) state_d = StArmed;
        StArmed: if (tick) begin
          state_d = StPlay;
          step_d  = '0;
          launch  = 1'b1;
        end
        StPlay:  if (tick) begin
          launch = 1'b1;
          if (arm_q)                 step_d = '0;
          else if (step_q != LastStep) step_d = step_q + 1'b1;
          else if (LOOP_i)           step_d = '0;
          else begin
            // One-shot end: no dispatch for this beat.
            state_d = StIdle;
            done_d  = 1'b1;
            launch  = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    sw_d   = sw_q;
    slot_d = slot_q;
    if (launch) begin
      sw_d   = 1'b1;
      slot_d = '0;
    end else if (sw_q) begin
      if (slot_q == LastSlot) begin
        sw_d   = 1'b0;
        slot_d = '0;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
    if (STOP_i) begin
      sw_d   = 1'b0;
      slot_d = '0;
    end

    // ROM data for the slot addressed last clock is valid now; register the write.
    v1_d   = sw_q & ~STOP_i;
    wt_d   = '0;
    divs_d = divs_q;
    note_d = note_q;
    if (v1_q && !STOP_i) begin
      wt_d   = C_SLOT_N'(1) << slot1_q;
      divs_d = DivLut[code_eff];
      note_d = SCORE_DATs_i[5];
    end
  end

  always_ff @(posedge CK_i or negedge XAR_i) begin
    if (!XAR_i) begin
      state_q <= StIdle;
      ctr_q   <= '0;
      arm_q   <= 1'b0;
      step_q  <= '0;
      done_q  <= 1'b0;
      sw_q    <= 1'b0;
      slot_q  <= '0;
      v1_q    <= 1'b0;
      slot1_q <= '0;
      wt_q    <= '0;
      divs_q  <= '0;
      note_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      arm_q   <= arm_d;
      step_q  <= step_d;
      done_q  <= done_d;
      sw_q    <= sw_d;
      slot_q  <= slot_d;
      v1_q    <= v1_d;
      slot1_q <= slot_q;
      wt_q    <= wt_d;
      divs_q  <= divs_d;
      note_q  <= note_d;
    end
  end

  assign SCORE_ADRs_o   = {slot_q, step_q};
  assign tempo_o        = tick;
  assign SLOT_divs_o    = divs_q;
  assign SLOT_note_o    = note_q;
  assign SLOTs_WT_REQ_o = wt_q;
  assign STEP_o         = step_q;
  assign BUSY_o         = (state_q != StIdle);
  assign DONE_o         = done_q;

endmodule

// File: tb/tb_melody_score_seq_n.sv
// Directed bench for melody_score_seq_n: 2 slots, 16 steps, tempo 4 ms, 1 ms = 10 clocks.
module tb_melody_score_seq_n;

  logic       clk, rst_n, ms, start, stop, loop_en;
  logic [4:0] adr;
  logic [5:0] rom_q;
  logic       tempo, note, busy, done;
  logic [7:0] divs;
  logic [1:0] wt;
  logic [3:0] step;
  logic [5:0] rom [32];
`ifdef MELODY_SEQ_TRANSPOSE_EN
  logic [4:0] tr;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int strobe_cnt = 0;
  int done_cnt = 0;

  melody_score_seq_n #(
    .C_SLOT_N  (2),
    .C_SCORE_W (4),
    .C_TEMPO_TC(4)
  ) dut (
    .CK_i          (clk),
    .XAR_i         (rst_n),
    .TIMING_1ms_i  (ms),
    .START_i       (start),
    .STOP_i        (stop),
    .LOOP_i        (loop_en),
`ifdef MELODY_SEQ_TRANSPOSE_EN
    .TRANSPOSE_i   (tr),
`endif
    .SCORE_ADRs_o  (adr),
    .SCORE_DATs_i  (rom_q),
    .tempo_o       (tempo),
    .SLOT_divs_o   (divs),
    .SLOT_note_o   (note),
    .SLOTs_WT_REQ_o(wt),
    .STEP_o        (step),
    .BUSY_o        (busy),
    .DONE_o        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom[adr];

  initial begin
    ms = 1'b0;
    forever begin
      repeat (9) @(posedge clk);
      #1 ms = 1'b1;
      @(posedge clk);
      #1 ms = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (wt != 2'b00) strobe_cnt++;
    if (done) done_cnt++;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_tick(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tempo && n < budget);
    if (!tempo) check_val("tick_timeout", 0, 1);
  endtask

  // Called right after the tick clock: checks addresses, strobes and data of one sweep.
  task automatic sweep(input int s, input int d0, input int n0, input int d1, input int n1);
    @(negedge clk);
    check_val("sw_step", step, s);
    check_val("sw_adr0", adr, s);
    check_val("sw_nowt0", wt, 0);
    @(negedge clk);
    check_val("sw_adr1", adr, 16 + s);
    check_val("sw_nowt1", wt, 0);
    @(negedge clk);
    check_val("sw_wt0", wt, 1);
    check_val("sw_div0", divs, d0);
    check_val("sw_note0", note, n0);
    @(negedge clk);
    check_val("sw_wt1", wt, 2);
    check_val("sw_div1", divs, d1);
    check_val("sw_note1", note, n1);
    @(negedge clk);
    check_val("sw_wt_end", wt, 0);
    check_val("sw_div_hold", divs, d1);
  endtask

  task automatic pulse_start(input logic with_stop);
    @(negedge clk);
    start = 1'b1;
    stop  = with_stop;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  initial begin
    int cnt, s0, d0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
`ifdef MELODY_SEQ_TRANSPOSE_EN
    tr = 5'd0;
`endif
    for (int i = 0; i < 16; i++) begin
      rom[i]      = {1'b1, 5'h18};
      rom[16 + i] = {1'b1, 5'h00};
    end
    rom[0]  = {1'b1, 5'h17};
    rom[16] = {1'b0, 5'h1F};
    rom[15] = {1'b1, 5'h1F};

    repeat (3) @(negedge clk);
    check_val("rst_tempo", tempo, 0);
    check_val("rst_divs", divs, 0);
    check_val("rst_note", note, 0);
    check_val("rst_wt", wt, 0);
    check_val("rst_step", step, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_adr", adr, 0);
    rst_n = 1'b1;

    wait_tick(60);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!tempo && cnt < 100);
    check_val("tempo_period", cnt, 40);

    // One-shot playback of all 16 steps.
    pulse_start(1'b0);
    check_val("armed_busy", busy, 1);
    #2 s0 = strobe_cnt;
    wait_tick(60);
    sweep(0, 63, 1, 39, 0);
    for (int i = 1; i < 16; i++) begin
      wait_tick(60);
      sweep(i, (i == 15) ? 39 : 59, 1, 240, 1);
    end
    wait_tick(60);
    @(negedge clk);
    check_val("end_busy", busy, 0);
    check_val("end_done", done, 1);
    check_val("end_step", step, 15);
    @(negedge clk);
    check_val("end_done_pulse", done, 0);
    repeat (6) @(negedge clk);
    #2 check_val("oneshot_strobes", strobe_cnt - s0, 32);

    // Loop mode wraps after step 15 without DONE.
    loop_en = 1'b1;
    pulse_start(1'b0);
    #2 d0 = done_cnt;
    wait_tick(60);
    sweep(0, 63, 1, 39, 0);
    for (int i = 1; i < 16; i++) begin
      wait_tick(60);
      @(negedge clk);
      check_val("loop_step", step, i);
    end
    wait_tick(60);
    sweep(0, 63, 1, 39, 0);
    check_val("loop_busy", busy, 1);
    #2 check_val("loop_no_done", done_cnt, d0);

    // STOP while the slot-0 address is out.
    wait_tick(60);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_val("stop_busy", busy, 0);
    #2 s0 = strobe_cnt;
    repeat (6) @(negedge clk);
    #2 check_val("stop_no_strobe", strobe_cnt, s0);
    check_val("stop_no_done", done_cnt, d0);
    check_val("stop_step_hold", step, 1);

    // START and STOP in the same clock leaves the sequencer idle.
    pulse_start(1'b1);
    check_val("ss_busy", busy, 0);
    #2 s0 = strobe_cnt;
    wait_tick(60);
    wait_tick(60);
    repeat (6) @(negedge clk);
    #2 check_val("ss_no_strobe", strobe_cnt, s0);
    check_val("ss_busy_late", busy, 0);

    // Reset during a sweep kills the pending strobe.
    loop_en = 1'b0;
    pulse_start(1'b0);
    wait_tick(60);
    repeat (3) @(negedge clk);
    check_val("rs_wt_before", wt, 1);
    rst_n = 1'b0;
    #1 check_val("rs_wt", wt, 0);
    check_val("rs_busy", busy, 0);
    check_val("rs_divs", divs, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #2 s0 = strobe_cnt;
    wait_tick(60);
    repeat (6) @(negedge clk);
    #2 check_val("rs_no_strobe", strobe_cnt, s0);

`ifdef MELODY_SEQ_TRANSPOSE_EN
    rom[0]  = {1'b1, 5'h1E};
    rom[16] = {1'b0, 5'h1F};
    tr = 5'd3;
    pulse_start(1'b0);
    wait_tick(60);
    sweep(0, 39, 1, 39, 0);
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    rom[0]  = {1'b1, 5'h02};
    rom[16] = {1'b0, 5'h02};
    tr = 5'b11011;
    pulse_start(1'b0);
    wait_tick(60);
    sweep(0, 240, 1, 240, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
